// File: rtl/ll_pkg.sv
// Shared helpers for the multi-channel line-length engine.
// Width arithmetic used by both the history ring and the top level.
package ll_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    // Wide enough for WIN_LEN worst-case differences of a DATA_WIDTH signed stream.
    function automatic int sum_width(input int dw, input int wl);
        return dw + 1 + clog2(wl);
    endfunction

endpackage

// File: rtl/ll_hist_ring.sv
// Per-channel history of absolute differences: ring, write pointer, saturating fill count.
// The oldest entry is presented combinationally so stage 1 can read and overwrite it in one edge.
module ll_hist_ring
    import ll_pkg::*;
#(
    parameter int D_W     = 33,
    parameter int WIN_LEN = 16
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           wr,
    input  logic [D_W-1:0] d,
    output logic [D_W-1:0] oldest,
    output logic           full
);
    localparam int PTR_W  = (clog2(WIN_LEN) < 1) ? 1 : clog2(WIN_LEN);
    localparam int FILL_W = clog2(WIN_LEN + 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(WIN_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIN_LEN);

    logic [WIN_LEN-1:0][D_W-1:0] ring;
    logic [PTR_W-1:0]            ptr;
    logic [FILL_W-1:0]           fill;

    assign oldest = ring[ptr];
    assign full   = (fill == FILL_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring <= '0;
            ptr  <= '0;
            fill <= '0;
        end else if (flush) begin
            ring <= '0;
            ptr  <= '0;
            fill <= '0;
        end else if (wr) begin
            ring[ptr] <= d;
            ptr       <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            if (!full) fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/ll_window_mc.sv
// Time-multiplexed sliding-window line length with threshold compare.
// Stage 1: abs-diff and ring update; stage 2: running-sum update and registered outputs.
module ll_window_mc
    import ll_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_CH     = 4,
    parameter  int WIN_LEN    = 16,
    localparam int CH_W       = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH),
    localparam int SUM_WIDTH  = sum_width(DATA_WIDTH, WIN_LEN)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [CH_W-1:0]       din_ch,
    input  logic                  clr,
    input  logic [SUM_WIDTH-1:0]  thresh,
    output logic [SUM_WIDTH-1:0]  dout,
    output logic [CH_W-1:0]       dout_ch,
    output logic                  data_valid,
    output logic                  over_thresh
);
    localparam int D_W = DATA_WIDTH + 1;

    // Field widths follow the module parameters, so the record lives here.
    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
        logic [D_W-1:0]  d;
        logic [D_W-1:0]  oldest;
        logic            was_full;
    } s2_rec_t;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] prev;
    logic [NUM_CH-1:0]                 prev_valid;
    logic [NUM_CH-1:0][D_W-1:0]        ring_oldest;
    logic [NUM_CH-1:0]                 ring_full;
    logic [NUM_CH-1:0]                 ring_wr;
    logic [NUM_CH-1:0][SUM_WIDTH-1:0]  sum;
    s2_rec_t                           s2;

    logic                  ch_ok;
    logic                  take;
    logic                  diff_go;
    logic [CH_W-1:0]       ch_sel;
    logic signed [D_W-1:0] diff;
    logic [D_W-1:0]        d_abs;
    logic [D_W-1:0]        s2_sub;
    logic [SUM_WIDTH-1:0]  new_sum;

    assign ch_ok   = (int'(din_ch) < NUM_CH);
    assign take    = en && ch_ok && !clr;
    // Out-of-range channels are steered to 0 so no array index ever leaves bounds.
    assign ch_sel  = ch_ok ? din_ch : '0;
    assign diff_go = take && prev_valid[ch_sel];
    assign diff    = $signed({din[DATA_WIDTH-1], din})
                   - $signed({prev[ch_sel][DATA_WIDTH-1], prev[ch_sel]});
    assign d_abs   = diff[D_W-1] ? -diff : diff;

    always_comb begin
        ring_wr = '0;
        if (diff_go) ring_wr[ch_sel] = 1'b1;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ll_hist_ring #(
            .D_W     (D_W),
            .WIN_LEN (WIN_LEN)
        ) u_ring (
            .clk    (clk),
            .rst    (rst),
            .flush  (clr),
            .wr     (ring_wr[c]),
            .d      (d_abs),
            .oldest (ring_oldest[c]),
            .full   (ring_full[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= '0;
            s2         <= '0;
        end else if (clr) begin
            prev       <= '0;
            prev_valid <= '0;
            s2         <= '0;
        end else begin
            s2.valid <= diff_go;
            if (take) begin
                prev[ch_sel]       <= din;
                prev_valid[ch_sel] <= 1'b1;
            end
            if (diff_go) begin
                s2.ch       <= ch_sel;
                s2.d        <= d_abs;
                s2.oldest   <= ring_oldest[ch_sel];
                s2.was_full <= ring_full[ch_sel];
            end
        end
    end

    assign s2_sub  = s2.was_full ? s2.oldest : '0;
    assign new_sum = sum[s2.ch] + SUM_WIDTH'(s2.d) - SUM_WIDTH'(s2_sub);

    // Ring fill only saturates or flushes, and a flush also kills s2,
    // so the live full flag equals the post-update fill of this sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum         <= '0;
            dout        <= '0;
            dout_ch     <= '0;
            data_valid  <= 1'b0;
            over_thresh <= 1'b0;
        end else if (clr) begin
            sum         <= '0;
            dout        <= '0;
            dout_ch     <= '0;
            data_valid  <= 1'b0;
            over_thresh <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (s2.valid) begin
                sum[s2.ch] <= new_sum;
                if (ring_full[s2.ch]) begin
                    data_valid  <= 1'b1;
                    dout        <= new_sum;
                    dout_ch     <= s2.ch;
                    over_thresh <= (new_sum > thresh);
                end
            end
        end
    end

endmodule
